// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per clock, LSB slice first,
// with a registered ripple carry and a start/busy/done handshake.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, res;
    logic [WIDTH-1:0] a_nxt, b_nxt, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s;
    logic             c_out, c_msb;

    assign {c_out, s} = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry};
    // Carry into the slice's top bit recovered from its sum bit.
    assign c_msb = s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign a_nxt   = a_r;
            assign b_nxt   = b_r;
            assign res_nxt = s;
        end else begin : g_multi
            assign a_nxt   = a_r >> DIGIT;
            assign b_nxt   = b_r >> DIGIT;
            assign res_nxt = {s, res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r   <= a_nxt;
                    b_r   <= b_nxt;
                    res   <= res_nxt;
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        sum   <= res_nxt;
                        cout  <= c_out;
                        ovf   <= c_out ^ c_msb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: DIGIT=1/4/16 instances against a cycle-count
// and plain-arithmetic reference model, plus literal directed cases.
module tb_digit_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = '0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic [2:0]  busy_o, done_o, cout_o, ovf_o;
    logic [15:0] sum_o [3];

    int checks = 0, errors = 0;
    int NS [3] = '{16, 4, 1};
    bit chk_en = 1'b0;

    logic        m_busy [3], m_done [3], m_cout [3], m_ovf [3], p_cout [3], p_ovf [3];
    logic [15:0] m_sum [3], p_sum [3];
    int          m_left [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(st[g]), .a(a), .b(b), .cin(cin), .sub(sub),
            .busy(busy_o[g]), .done(done_o[g]), .sum(sum_o[g]), .cout(cout_o[g]), .ovf(ovf_o[g])
        );
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Result from integer arithmetic: unsigned sum for cout, signed range for ovf.
    function automatic void ref_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                                   input logic sb, output logic [15:0] s, output logic co,
                                   output logic ov);
        logic [15:0] be;
        int unsigned u;
        int c, sa, sbe, r;
        be  = sb ? ~bv : bv;
        c   = (ci ^ sb) ? 1 : 0;
        u   = 32'(av) + 32'(be) + 32'(c);
        s   = u[15:0];
        co  = u[16];
        sa  = $signed(av);
        sbe = $signed(be);
        r   = sa + sbe + c;
        ov  = (r > 32767) || (r < -32768);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_cout[i] = 0; m_ovf[i] = 0;
                m_left[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_busy[i] = 0; m_done[i] = 1;
                        m_sum[i] = p_sum[i]; m_cout[i] = p_cout[i]; m_ovf[i] = p_ovf[i];
                    end
                end else if (st[i]) begin
                    ref_op(a, b, cin, sub, p_sum[i], p_cout[i], p_ovf[i]);
                    m_left[i] = NS[i];
                    m_busy[i] = 1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_cout[i] = 0; m_ovf[i] = 0; m_left[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("cycle_dig%0d", i), 32'({busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]}),
                      32'({m_busy[i], m_done[i], m_cout[i], m_ovf[i], m_sum[i]}));
        end
    end

    // Starts an op at the current negedge, scrambles inputs once accepted, waits for done.
    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, output int lat);
        a = av; b = bv; cin = ci; sub = sb; st[i] = 1'b1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("busy_after_start", 32'(busy_o[i]), 32'd1);
                st[i] = 1'b0;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
        end while (!done_o[i] && lat < 40);
        if (!done_o[i]) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", lat);
        end
    endtask

    logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic        vc [5] = '{0, 0, 1, 0, 0};
    logic        vs [5] = '{0, 0, 0, 1, 1};
    logic [15:0] es [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{0, 1, 0, 0, 1};
    logic        eo [5] = '{0, 0, 1, 0, 1};

    initial begin
        int lat;
        logic [15:0] rs;
        logic rc, ro;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++)
            check("reset_state", 32'({busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]}), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            ref_op(va[v], vb[v], vc[v], vs[v], rs, rc, ro);
            check("model_pin", 32'({rc, ro, rs}), 32'({ec[v], eo[v], es[v]}));
            run_op(1, va[v], vb[v], vc[v], vs[v], lat);
            check("dir_latency", 32'(lat), 32'd5);
            check("dir_result", 32'({cout_o[1], ovf_o[1], sum_o[1]}), 32'({ec[v], eo[v], es[v]}));
            @(negedge clk);
        end
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        check("lat_digit1", 32'(lat), 32'd17);
        check("sum_digit1", 32'(sum_o[0]), 32'h5555);
        run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        check("lat_digit16", 32'(lat), 32'd2);
        check("sum_digit16", 32'(sum_o[2]), 32'h5555);

        // Starts during RUN are ignored; start in the DONE cycle is taken at once.
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; st[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        @(negedge clk);
        st[1] = 1'b0;
        lat = 0;
        while (!done_o[1] && lat < 10) begin @(negedge clk); lat++; end
        check("ignored_start_done", 32'(done_o[1]), 32'd1);
        check("ignored_start_sum", 32'(sum_o[1]), 32'h3333);
        run_op(1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
        check("b2b_latency", 32'(lat), 32'd5);
        check("b2b_sum", 32'(sum_o[1]), 32'h1010);
        run_op(1, 16'h0F0F, 16'h0101, 1'b0, 1'b1, lat);
        check("b2b2_latency", 32'(lat), 32'd5);
        check("b2b2_sum", 32'(sum_o[1]), 32'h0E0E);
        @(negedge clk);

        // Abort mid-operation with an asynchronous reset.
        a = 16'h4444; b = 16'h1111; st[1] = 1'b1;
        @(negedge clk); st[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check("async_reset", 32'({busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done_o[1]), 32'd0);
        end
        run_op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd5);
        check("post_reset_sum", 32'({cout_o[1], ovf_o[1], sum_o[1]}), 32'h0002);

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 128; n++) begin
                logic [15:0] ra, rb;
                logic rci, rsb;
                ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsb = 1'($urandom);
                ref_op(ra, rb, rci, rsb, rs, rc, ro);
                run_op(i, ra, rb, rci, rsb, lat);
                check($sformatf("rand_lat_dig%0d", i), 32'(lat), 32'(NS[i] + 1));
                check($sformatf("rand_res_dig%0d", i), 32'({cout_o[i], ovf_o[i], sum_o[i]}),
                      32'({rc, ro, rs}));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
